// File: rtl/access_control_pkg.sv
// Shared definitions for the access control block: FSM state encoding,
// LCD status codes, LED codes, parameter defaults and the power-on user table.
package access_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_ID  = 3'd1,
    S_GET_PW  = 3'd2,
    S_CHECK   = 3'd3,
    S_GRANTED = 3'd4,
    S_DENIED  = 3'd5,
    S_LOCKED  = 3'd6
  } state_t;

  // LCD message codes
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ENTER_ID    = 3'd1;
  localparam logic [2:0] ST_ENTER_PW    = 3'd2;
  localparam logic [2:0] ST_GRANTED     = 3'd3;
  localparam logic [2:0] ST_INVALID     = 3'd4;
  localparam logic [2:0] ST_LOCKED      = 3'd5;
  localparam logic [2:0] ST_PW_CHANGED  = 3'd6;
  localparam logic [2:0] ST_PW_REJECTED = 3'd7;

  // LED codes; LED_BLINK tells the LED driver to blink red, with the phase
  // taken from bit 23 of the lockout counter (toggles every 2^23 cycles)
  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_RED   = 2'd1;
  localparam logic [1:0] LED_GREEN = 2'd2;
  localparam logic [1:0] LED_BLINK = 2'd3;

  localparam int          DEF_MAX_ATTEMPTS = 3;
  localparam logic [31:0] DEF_LOCK_CYCLES  = 32'd150_000_000;

  // Power-on user i has ID i+1 and a password of four repeated digits i+1
  function automatic logic [15:0] default_id(input int i);
    return 16'(i + 1);
  endfunction

  function automatic logic [15:0] default_pw(input int i);
    logic [3:0] d;
    d = 4'(i + 1);
    return {d, d, d, d};
  endfunction

endpackage

// File: rtl/access_control_user_table.sv
// User table: NUM_USERS ID/password registers, parallel ID lookup with
// password compare, and a single password write port.
module user_table
  import access_control_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int IDX_W     = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id,
  input  logic [15:0]      pw,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [15:0]      wdata,
  output logic             hit,
  output logic             match,
  output logic [IDX_W-1:0] index
);

  logic [15:0] ids [NUM_USERS];
  logic [15:0] pws [NUM_USERS];

  // Table storage: reload defaults on reset, otherwise accept password writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        ids[i] <= default_id(i);
        pws[i] <= default_pw(i);
      end
    end else if (we) begin
      pws[widx] <= wdata;
    end
  end

  // Parallel lookup; walking downwards gives the lowest matching index priority
  always_comb begin
    hit   = 1'b0;
    match = 1'b0;
    index = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (ids[i] == id) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        match = (pws[i] == pw);
      end
    end
  end

endmodule

// File: rtl/access_control.sv
// Login controller: collects a user ID and password from the switches,
// checks them against the user table, grants access, counts failures and
// locks the panel out after too many consecutive failures.
module access_control
  import access_control_pkg::*;
#(
  parameter int          NUM_USERS    = 4,
  parameter int          MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
  parameter logic [31:0] LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        enter,
  input  logic        pw_change,
  input  logic [15:0] switches,
  output logic        granted,
  output logic [15:0] userid,
  output logic [2:0]  status,
  output logic [1:0]  led,
  output logic        locked,
  output logic [1:0]  attempts
);

  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  state_t            state;
  logic [15:0]       id_reg;
  logic [15:0]       pw_reg;
  logic [IDX_W-1:0]  user_idx;
  logic [31:0]       lock_cnt;
  logic [1:0]        att_inc;
  logic              tbl_hit;
  logic              tbl_match;
  logic [IDX_W-1:0]  tbl_index;
  logic              tbl_we;

  // Failure counter increment that sticks at MAX_ATTEMPTS
  function automatic logic [1:0] sat_inc(input logic [1:0] a);
    return (a >= 2'(MAX_ATTEMPTS)) ? a : a + 2'd1;
  endfunction

  assign att_inc = sat_inc(attempts);

  // Password rewrite for the logged-in user; an all-zero password is refused
  assign tbl_we = (state == S_GRANTED) && en && pw_change && (switches != 16'h0000);

  user_table #(
    .NUM_USERS (NUM_USERS),
    .IDX_W     (IDX_W)
  ) u_user_table (
    .clk   (clk),
    .rst   (rst),
    .id    (id_reg),
    .pw    (pw_reg),
    .we    (tbl_we),
    .widx  (user_idx),
    .wdata (switches),
    .hit   (tbl_hit),
    .match (tbl_match),
    .index (tbl_index)
  );

  // Login FSM with registered outputs; en=0 aborts any session except a lockout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      granted  <= 1'b0;
      userid   <= 16'h0000;
      status   <= ST_IDLE;
      led      <= LED_OFF;
      locked   <= 1'b0;
      attempts <= 2'd0;
      lock_cnt <= 32'd0;
      id_reg   <= 16'h0000;
      pw_reg   <= 16'h0000;
      user_idx <= '0;
    end else if (state != S_LOCKED && !en) begin
      state   <= S_IDLE;
      granted <= 1'b0;
      userid  <= 16'h0000;
      status  <= ST_IDLE;
      led     <= LED_OFF;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_GET_ID;
          status <= ST_ENTER_ID;
        end

        // A preceding "invalid" message stays up until the user presses enter
        S_GET_ID: begin
          if (enter) begin
            id_reg <= switches;
            status <= ST_ENTER_PW;
            state  <= S_GET_PW;
          end
        end

        S_GET_PW: begin
          if (enter) begin
            pw_reg <= switches;
            state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (tbl_hit && tbl_match) begin
            state    <= S_GRANTED;
            granted  <= 1'b1;
            userid   <= id_reg;
            status   <= ST_GRANTED;
            led      <= LED_GREEN;
            attempts <= 2'd0;
            user_idx <= tbl_index;
          end else begin
            attempts <= att_inc;
            if (att_inc == 2'(MAX_ATTEMPTS)) begin
              state    <= S_LOCKED;
              locked   <= 1'b1;
              led      <= LED_BLINK;
              status   <= ST_LOCKED;
              lock_cnt <= 32'd0;
            end else begin
              state  <= S_DENIED;
              status <= ST_INVALID;
              led    <= LED_RED;
            end
          end
        end

        // Session stays open until en drops; enter has no meaning here
        S_GRANTED: begin
          if (pw_change) begin
            status <= (switches != 16'h0000) ? ST_PW_CHANGED : ST_PW_REJECTED;
          end
        end

        S_DENIED: begin
          led   <= LED_OFF;
          state <= S_GET_ID;
        end

        // Lockout runs its full length regardless of en, enter or pw_change
        S_LOCKED: begin
          if (lock_cnt == LOCK_CYCLES - 32'd1) begin
            lock_cnt <= 32'd0;
            attempts <= 2'd0;
            locked   <= 1'b0;
            led      <= LED_OFF;
            if (en) begin
              state  <= S_GET_ID;
              status <= ST_ENTER_ID;
            end else begin
              state  <= S_IDLE;
              status <= ST_IDLE;
            end
          end else begin
            lock_cnt <= lock_cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_control.sv
// Bench for access_control: a table of single-cycle vectors for the basic
// login/failure flow, then hand-written sequences for lockout, password
// change, session abort and reset corner cases.
module tb_access_control;

  typedef struct packed {
    logic        g;
    logic [15:0] u;
    logic [2:0]  s;
    logic [1:0]  l;
    logic        k;
    logic [1:0]  a;
  } out_t;

  typedef struct {
    string       nm;
    logic        e;
    logic        ent;
    logic        pwc;
    logic [15:0] sw;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        enter = 1'b0;
  logic        pw_change = 1'b0;
  logic [15:0] switches = 16'h0000;
  logic        granted;
  logic [15:0] userid;
  logic [2:0]  status;
  logic [1:0]  led;
  logic        locked;
  logic [1:0]  attempts;

  int total = 0;
  int bad   = 0;

  out_t  exp_q[$];
  string nm_q[$];
  vec_t  tbl[22];

  always #5 clk = ~clk;

  access_control #(
    .NUM_USERS    (4),
    .MAX_ATTEMPTS (3),
    .LOCK_CYCLES  (32'd16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .enter     (enter),
    .pw_change (pw_change),
    .switches  (switches),
    .granted   (granted),
    .userid    (userid),
    .status    (status),
    .led       (led),
    .locked    (locked),
    .attempts  (attempts)
  );

  function automatic out_t mk(input logic g, input logic [15:0] u, input logic [2:0] s,
                              input logic [1:0] l, input logic k, input logic [1:0] a);
    out_t o;
    o.g = g; o.u = u; o.s = s; o.l = l; o.k = k; o.a = a;
    return o;
  endfunction

  task automatic set_v(input int i, input string nm, input logic e, input logic ent,
                       input logic pwc, input logic [15:0] sw, input out_t exp);
    tbl[i].nm  = nm;
    tbl[i].e   = e;
    tbl[i].ent = ent;
    tbl[i].pwc = pwc;
    tbl[i].sw  = sw;
    tbl[i].exp = exp;
  endtask

  task automatic check_out();
    out_t  act;
    out_t  exp;
    string nm;
    act = {granted, userid, status, led, locked, attempts};
    exp = exp_q.pop_front();
    nm  = nm_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got g=%0b u=%h s=%0d led=%0d lk=%0b att=%0d, want g=%0b u=%h s=%0d led=%0d lk=%0b att=%0d",
               nm, act.g, act.u, act.s, act.l, act.k, act.a,
               exp.g, exp.u, exp.s, exp.l, exp.k, exp.a);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge
  task automatic step(input string nm, input logic e, input logic ent, input logic pwc,
                      input logic [15:0] sw, input out_t exp);
    en        = e;
    enter     = ent;
    pw_change = pwc;
    switches  = sw;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    enter     = 1'b0;
    pw_change = 1'b0;
    check_out();
  endtask

  // ID 0x0001 with a wrong password, not reaching the lockout threshold
  task automatic fail_round(input logic [1:0] a);
    step("fail_id",  1'b1, 1'b1, 1'b0, 16'h0001, mk(0, 16'h0, 3'd2, 2'd0, 0, a));
    step("fail_pw",  1'b1, 1'b1, 1'b0, 16'h9999, mk(0, 16'h0, 3'd2, 2'd0, 0, a));
    step("fail_chk", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd1, 0, 2'(a + 2'd1)));
    step("fail_ret", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'(a + 2'd1)));
  endtask

  // Third consecutive failure, landing in the lockout
  task automatic lock_round();
    step("lock_id",  1'b1, 1'b1, 1'b0, 16'h0001, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd2));
    step("lock_pw",  1'b1, 1'b1, 1'b0, 16'h9999, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd2));
    step("lock_chk", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd5, 2'd3, 1, 2'd3));
  endtask

  // Successful login of user 3 with the given password
  task automatic login3(input logic [15:0] pw, input logic [1:0] a);
    step("l3_id",  1'b1, 1'b1, 1'b0, 16'h0003, mk(0, 16'h0, 3'd2, 2'd0, 0, a));
    step("l3_pw",  1'b1, 1'b1, 1'b0, pw,       mk(0, 16'h0, 3'd2, 2'd0, 0, a));
    step("l3_chk", 1'b1, 1'b0, 1'b0, 16'h0000, mk(1, 16'h0003, 3'd3, 2'd2, 0, 2'd0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish within time limit");
    $fatal(1);
  end

  initial begin
    set_v(0,  "rst",       1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    set_v(1,  "to_get_id", 1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    set_v(2,  "id2",       1, 1, 0, 16'h0002, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    set_v(3,  "pw2_check", 1, 1, 0, 16'h2222, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    set_v(4,  "granted2",  1, 0, 0, 16'h0000, mk(1, 16'h0002, 3'd3, 2'd2, 0, 2'd0));
    set_v(5,  "hold",      1, 0, 0, 16'h0000, mk(1, 16'h0002, 3'd3, 2'd2, 0, 2'd0));
    set_v(6,  "enter_ign", 1, 1, 0, 16'h0001, mk(1, 16'h0002, 3'd3, 2'd2, 0, 2'd0));
    set_v(7,  "logout",    0, 0, 0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    set_v(8,  "idle",      0, 0, 0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    set_v(9,  "get_id",    1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    set_v(10, "id1_a",     1, 1, 0, 16'h0001, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    set_v(11, "bad_a",     1, 1, 0, 16'h9999, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    set_v(12, "deny_a",    1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd1, 0, 2'd1));
    set_v(13, "ret_a",     1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'd1));
    set_v(14, "hold4",     1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'd1));
    set_v(15, "id1_b",     1, 1, 0, 16'h0001, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd1));
    set_v(16, "bad_b",     1, 1, 0, 16'h9999, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd1));
    set_v(17, "deny_b",    1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd1, 0, 2'd2));
    set_v(18, "ret_b",     1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'd2));
    set_v(19, "id1_c",     1, 1, 0, 16'h0001, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd2));
    set_v(20, "bad_c",     1, 1, 0, 16'h9999, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd2));
    set_v(21, "locked",    1, 0, 0, 16'h0000, mk(0, 16'h0, 3'd5, 2'd3, 1, 2'd3));

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      if (i == 1) rst = 1'b1;
      step(tbl[i].nm, tbl[i].e, tbl[i].ent, tbl[i].pwc, tbl[i].sw, tbl[i].exp);
    end

    // Lockout of 16 cycles: enter and pw_change pulses have no effect
    for (int i = 0; i < 15; i++) begin
      step("lock_hold", 1'b1, (i % 2) == 0, (i % 2) == 1, 16'h0001,
           mk(0, 16'h0, 3'd5, 2'd3, 1, 2'd3));
    end
    step("lock_exit", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));

    // Unknown user ID
    step("unk_id",  1'b1, 1'b1, 1'b0, 16'h00FF, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    step("unk_pw",  1'b1, 1'b1, 1'b0, 16'h1234, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    step("unk_chk", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd1, 0, 2'd1));
    step("unk_ret", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'd1));

    // Password change for user 3, then a rejected all-zero change
    login3(16'h3333, 2'd1);
    step("pwc_ok",   1'b1, 1'b0, 1'b1, 16'h5A5A, mk(1, 16'h0003, 3'd6, 2'd2, 0, 2'd0));
    step("pwc_zero", 1'b1, 1'b0, 1'b1, 16'h0000, mk(1, 16'h0003, 3'd7, 2'd2, 0, 2'd0));
    step("logout3",  1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    step("get_id3",  1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    step("old_id",   1'b1, 1'b1, 1'b0, 16'h0003, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    step("old_pw",   1'b1, 1'b1, 1'b0, 16'h3333, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    step("old_deny", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd1, 0, 2'd1));
    step("old_ret",  1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd4, 2'd0, 0, 2'd1));
    login3(16'h5A5A, 2'd1);

    // pw_change and enter together: write wins, session unaffected
    step("pwc_ent",  1'b1, 1'b1, 1'b1, 16'h6161, mk(1, 16'h0003, 3'd6, 2'd2, 0, 2'd0));
    step("logout4",  1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    step("get_id4",  1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    login3(16'h6161, 2'd0);

    // en dropped while waiting for the password
    step("logout5",  1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    step("get_id5",  1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    step("id_abort", 1'b1, 1'b1, 1'b0, 16'h0002, mk(0, 16'h0, 3'd2, 2'd0, 0, 2'd0));
    step("en_drop",  1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));

    // Lockout with en low throughout: runs full length, then back to idle
    step("get_id6",  1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    fail_round(2'd0);
    fail_round(2'd1);
    lock_round();
    for (int i = 0; i < 15; i++) begin
      step("lock_en0", 1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd5, 2'd3, 1, 2'd3));
    end
    step("lock_exit0", 1'b0, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    step("get_id7",    1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));

    // Reset in the middle of a lockout; table returns to defaults
    fail_round(2'd0);
    fail_round(2'd1);
    lock_round();
    for (int i = 0; i < 3; i++) begin
      step("lock_pre_rst", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd5, 2'd3, 1, 2'd3));
    end
    rst = 1'b0;
    step("rst_in_lock", 1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd0, 2'd0, 0, 2'd0));
    rst = 1'b1;
    step("after_rst",   1'b1, 1'b0, 1'b0, 16'h0000, mk(0, 16'h0, 3'd1, 2'd0, 0, 2'd0));
    login3(16'h3333, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/access_control.md
ACCESS_CONTROL -- requirements
Module: access_control

Interface
REQ-001 Parameter: NUM_USERS, 4, number of entries in the user table.
REQ-002 Parameter: MAX_ATTEMPTS, 3, consecutive failed logins before lockout.
REQ-003 Parameter: LOCK_CYCLES, 32'd150_000_000, lockout duration in clk cycles.
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  block active, driven high by the process controller during login.
REQ-007 enter  in  1  debounced single-cycle pulse, confirms the current switch value.
REQ-008 pw_change  in  1  debounced single-cycle pulse, requests a password rewrite.
REQ-009 switches  in  16  user ID or password entry.
REQ-010 granted  out  1  level, access accepted; feeds the controller's access feedback input.
REQ-011 userid  out  16  ID of the logged-in user; 0 when not granted.
REQ-012 status  out  3  LCD message code.
REQ-013 led  out  2  LED code: 0 off, 1 red, 2 green, 3 red blinking.
REQ-014 locked  out  1  lockout active.
REQ-015 attempts  out  2  current consecutive failure count.

Function
REQ-016 States SHALL be IDLE, GET_ID, GET_PW, CHECK, GRANTED, DENIED and LOCKED.
REQ-017 Status codes SHALL be 0 idle, 1 enter ID, 2 enter password, 3 granted, 4 invalid, 5 locked, 6 password changed, 7 password rejected.
REQ-018 IDLE SHALL move to GET_ID when en=1.
REQ-019 GET_ID on enter SHALL latch switches into id_reg, drive status=2 and move to GET_PW.
REQ-020 GET_PW on enter SHALL latch switches into pw_reg and move to CHECK.
REQ-021 CHECK SHALL last exactly one cycle, comparing id_reg against every table entry in parallel and pw_reg against the matching entry's password.
REQ-022 On a match, CHECK SHALL go to GRANTED, clear attempts and latch the index of the matched user.
REQ-023 Login latency: granted=1 exactly 2 cycles after the password enter pulse.
REQ-024 On a mismatch or unknown ID, CHECK SHALL increment attempts.
REQ-025 After that increment, attempts==MAX_ATTEMPTS SHALL select LOCKED; otherwise CHECK SHALL select DENIED.
REQ-026 DENIED SHALL drive status=4 and led=1 for one cycle, then return to GET_ID.
REQ-027 Status=4 SHALL be held until the next enter pulse.
REQ-028 LOCKED SHALL drive locked=1, led=3 and status=5.
REQ-029 LOCKED SHALL ignore enter and pw_change.
REQ-030 LOCKED SHALL count LOCK_CYCLES cycles, then clear attempts and go to GET_ID if en=1, else to IDLE.
REQ-031 The led=3 blink SHALL toggle every 2^23 cycles.
REQ-032 GRANTED SHALL drive granted=1, led=2, status=3 and userid=id_reg.
REQ-033 GRANTED SHALL hold until en=0.
REQ-034 In GRANTED, pw_change SHALL write switches into the matched user's password entry and drive status=6.
REQ-035 A pw_change with switches==16'h0000 SHALL be rejected: no write, status=7.
REQ-036 If pw_change and enter arrive in the same cycle, pw_change SHALL take effect and enter SHALL be ignored.
REQ-037 In any state except LOCKED, en=0 SHALL force IDLE on the next cycle.
REQ-038 In IDLE, granted, userid and status SHALL be 0; attempts SHALL be retained.
REQ-039 en=0 during LOCKED SHALL NOT end the lockout; the lock counter SHALL continue.
REQ-040 Every enter pulse outside GET_ID and GET_PW SHALL be ignored.
REQ-041 The attempts counter SHALL saturate at MAX_ATTEMPTS.

Reset
REQ-042 On rst=0 the state SHALL be IDLE.
REQ-043 On rst=0 the outputs SHALL be granted=0, userid=0, status=0, led=0, locked=0 and attempts=0.
REQ-044 On rst=0 the lock counter, id_reg and pw_reg SHALL be 0.
REQ-045 On rst=0 the user table SHALL reload IDs 0x0001..0x0004 with passwords 0x1111, 0x2222, 0x3333, 0x4444.
REQ-046 A reset mid-lockout SHALL clear the lockout.

Structure
REQ-047 The shared package SHALL hold: the state encoding, the status and LED codes, the default user ID/password table, and MAX_ATTEMPTS/LOCK_CYCLES defaults.
REQ-048 The user table SHALL be one sub-module, user_table: NUM_USERS registers with a parallel compare and one write port; match, index and hit outputs SHALL be combinational.

Verification
REQ-049 Reset, en=1, ID 0x0002 + enter, password 0x2222 + enter -> granted=1 two cycles later, userid=0x0002, led=2, status=3.
REQ-050 ID 0x0001 with password 0x9999, three times -> attempts counts 1, 2, then locked=1, status=5, led=3.
REQ-051 The same lockout case -> enter ignored for LOCK_CYCLES (bench override 16), then GET_ID with attempts=0.
REQ-052 Unknown ID 0x00FF with any password -> status=4, attempts=1, granted stays 0.
REQ-053 Granted as user 3, pw_change with switches=0x5A5A -> status=6; logout, re-login with 0x3333 -> denied; with 0x5A5A -> granted.
REQ-054 pw_change with switches=0x0000 -> status=7 and the table is unchanged.
REQ-055 pw_change and enter in the same cycle -> the write happens and enter is ignored.
REQ-056 en dropped in GET_PW -> IDLE next cycle.
REQ-057 en dropped during LOCKED -> lockout continues.
REQ-058 rst=0 during LOCKED -> all outputs 0.
